// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: moves the captured operand one bit per clock
// (SHL/SHR/SAR/ROL) and pulses done for one cycle when the result lands in dout.
module seq_shifter #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {M_SHL = 2'b00, M_SHR = 2'b01, M_SAR = 2'b10, M_ROL = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_e;

  // Operation context latched at start; never re-read from the ports afterwards.
  typedef struct packed {
    logic [1:0] mode;
    logic       msb;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [AMT_W-1:0] k_eff;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w, input op_t op);
    logic [WIDTH-1:0] r;
    case (op.mode)
      M_SHL:   r = {w[WIDTH-2:0], 1'b0};
      M_SHR:   r = {1'b0, w[WIDTH-1:1]};
      M_SAR:   r = {op.msb, w[WIDTH-1:1]};
      default: r = {w[WIDTH-2:0], w[WIDTH-1]};
    endcase
    return r;
  endfunction

  // Rotates wrap modulo WIDTH (low bits of amt); linear shifts saturate at WIDTH.
  always_comb begin
    k_eff = amt;
    if (mode == M_ROL)
      k_eff = {1'b0, amt[AMT_W-2:0]};
    else if (amt > AMT_W'(WIDTH))
      k_eff = AMT_W'(WIDTH);
  end

  assign step_val = shift_one(work_q, op_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          work_d = din;
          op_d   = '{mode: mode, msb: din[WIDTH-1]};
          cnt_d  = k_eff;
          if (k_eff == '0) begin
            state_d = DONE;
            dout_d  = din;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          work_d = step_val;
          cnt_d  = cnt_q - AMT_W'(1);
          // Last step publishes the shifted value directly into dout.
          if (cnt_q == AMT_W'(1)) begin
            state_d = DONE;
            dout_d  = step_val;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=8): vector table with a done-driven
// scoreboard, plus hand sequences for abort, busy-start and async reset.
module tb_seq_shifter;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk, rst_n, start, abort;
  logic [1:0]    mode;
  logic [W-1:0]  din;
  logic [AW-1:0] amt;
  logic          busy, done;
  logic [W-1:0]  dout;

  seq_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .din(din), .amt(amt), .busy(busy), .done(done), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp;
    int            k;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done actual=done expected=no_done t=%0t", $time);
      end else begin
        logic [W-1:0] e;
        e = sbq.pop_front();
        chk("sb_dout", {24'h0, dout}, {24'h0, e});
      end
    end
  end

  // Drives one operation, scrambles the ports after capture, and checks
  // latency, busy length and that dout holds afterwards.
  task automatic run_op(input vec_t v, input bit poke_done);
    int cyc, bcnt;
    @(negedge clk);
    start = 1'b1; mode = v.mode; din = v.din; amt = v.amt;
    sbq.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); din = W'($urandom); amt = AW'($urandom);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy) bcnt++;
    chk("latency", cyc, v.k);
    chk("busy_cycles", bcnt, v.k + 1);
    if (poke_done) begin
      start = 1'b1; abort = 1'b1; din = ~v.exp; amt = 1;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("post_done", {busy, done}, 2'b00);
    @(negedge clk);
    chk("dout_hold", {24'h0, dout}, {24'h0, v.exp});
    chk("still_idle", busy, 1'b0);
  endtask

  vec_t vecs[14];
  vec_t prior, after;
  int   cnt;

  initial begin
    vecs[0]  = '{2'b00, 8'hFF, 4'd4,  8'hF0, 4};
    vecs[1]  = '{2'b10, 8'h80, 4'd3,  8'hF0, 3};
    vecs[2]  = '{2'b01, 8'h80, 4'd3,  8'h10, 3};
    vecs[3]  = '{2'b10, 8'h80, 4'd12, 8'hFF, 8};
    vecs[4]  = '{2'b11, 8'h58, 4'd9,  8'hB0, 1};
    vecs[5]  = '{2'b11, 8'h58, 4'd8,  8'h58, 0};
    vecs[6]  = '{2'b00, 8'hFF, 4'd15, 8'h00, 8};
    vecs[7]  = '{2'b00, 8'h5A, 4'd0,  8'h5A, 0};
    vecs[8]  = '{2'b01, 8'hFF, 4'd8,  8'h00, 8};
    vecs[9]  = '{2'b10, 8'h7F, 4'd8,  8'h00, 8};
    vecs[10] = '{2'b11, 8'h81, 4'd3,  8'h0C, 3};
    vecs[11] = '{2'b10, 8'hB4, 4'd2,  8'hED, 2};
    vecs[12] = '{2'b11, 8'h96, 4'd15, 8'h4B, 7};
    vecs[13] = '{2'b00, 8'h01, 4'd7,  8'h80, 7};
    prior    = '{2'b00, 8'h0F, 4'd1,  8'h1E, 1};
    after    = '{2'b01, 8'hC3, 4'd2,  8'h30, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; din = '0; amt = '0;
    #1;
    chk("reset_state", {busy, done, dout}, 10'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First start after reset behaves like any other.
    run_op(vecs[0], 1'b0);
    for (int i = 1; i < 14; i++) run_op(vecs[i], 1'b0);

    // Abort and start together in DONE: done and dout still complete, start ignored.
    run_op(vecs[5], 1'b1);
    run_op(vecs[11], 1'b1);

    // Abort wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mode = 2'b00; din = 8'hAA; amt = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {busy, done}, 2'b00);

    // Start ignored mid-shift, then abort at step 3.
    run_op(prior, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; din = 8'h81; amt = 4'd6;
    @(negedge clk);
    start = 1'b0; din = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; din = 8'hAA; amt = 4'd1;
    chk("busy_at_step2", busy, 1'b1);
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    chk("busy_at_step3", busy, 1'b1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, done}, 2'b00);
    chk("abort_dout_kept", {24'h0, dout}, {24'h0, prior.exp});
    cnt = 0;
    repeat (8) begin @(negedge clk); if (done || busy) cnt++; end
    chk("abort_no_activity", cnt, 0);
    run_op(after, 1'b0);

    // Asynchronous reset mid-SHIFT, away from any clock edge.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; din = 8'hFF; amt = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, dout}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (done || busy) cnt++; end
    chk("reset_no_done", cnt, 0);
    chk("reset_dout_zero", {24'h0, dout}, 32'h0);
    run_op(vecs[3], 1'b0);

    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter: WIDTH, default 8, data width; SHALL be a power of two, >= 2.
REQ-002 Localparam: AMT_W = $clog2(WIDTH)+1, amount width (amt range 0..2*WIDTH-1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of the operation in progress.
REQ-007 mode  input  2  operation: 00 SHL logical left, 01 SHR logical right, 10 SAR arithmetic right, 11 ROL rotate left.
REQ-008 din  input  WIDTH  operand, captured with start.
REQ-009 amt  input  AMT_W  shift amount, captured with start.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 dout  output  WIDTH  registered result; holds the last completed result.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; busy = (state != IDLE); done = (state == DONE).
REQ-014 Effective count k: SHL/SHR/SAR use min(amt, WIDTH); ROL uses amt mod WIDTH.
REQ-015 In IDLE with start=1 and abort=0 at edge E: load din, mode and k into working registers; go to SHIFT if k>0, else to DONE.
REQ-016 In SHIFT, each edge SHALL move the working register one bit per mode and decrement the counter; the edge performing the k-th step SHALL go to DONE.
REQ-017 SHL and SHR fill with 0; SAR fills with the captured MSB; ROL moves the MSB into bit 0.
REQ-018 Latency: done SHALL be high for exactly the one cycle following edge E+k (k=0 gives done in the cycle after E).
REQ-019 dout SHALL load the final working value on the edge entering DONE and SHALL not change otherwise (except on reset).
REQ-020 DONE SHALL always go to IDLE on the next edge; start sampled in that DONE cycle SHALL be ignored.
REQ-021 start while busy (SHIFT or DONE) SHALL be ignored, with no effect on the operation or outputs.
REQ-022 abort=1 in SHIFT SHALL go to IDLE on the next edge, with no done pulse and dout unchanged.
REQ-023 abort=1 and start=1 together in IDLE: abort wins, state stays IDLE.
REQ-024 abort in DONE SHALL have no effect; the done pulse and dout update still complete.
REQ-025 din, amt and mode changes after capture SHALL NOT affect the operation in progress.
REQ-026 Shift results for k=WIDTH: SHL/SHR give 0; SAR gives all bits = captured MSB.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with busy=0, done=0, dout=0 and working registers/counter = 0, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL discard that operation; no done pulse follows the release of reset.
REQ-029 The first start after reset release SHALL behave exactly as REQ-015.

Verification (WIDTH=8)
REQ-030 SHL, din=0xFF, amt=4 -> done 4 edges after start edge, dout=0xF0, busy high for 5 cycles.
REQ-031 SAR, din=0x80, amt=3 -> dout=0xF0; SHR with the same din and amt -> dout=0x10; SAR, din=0x80, amt=12 -> k=8, dout=0xFF.
REQ-032 ROL, din=0x58, amt=9 -> k=1, dout=0xB0 after 1 edge; ROL, amt=8 -> k=0, dout=0x58 with done in the cycle after start.
REQ-033 SHL, din=0xFF, amt=15 -> k=8, dout=0x00 after 8 edges; amt=0, din=0x5A -> dout=0x5A with done in the cycle after start.
REQ-034 Start SHL, amt=6; pulse start with new din at step 2 (ignored); abort at step 3 -> IDLE, no done, dout keeps the prior result; the next start runs normally.
REQ-035 Reset asserted mid-SHIFT with no clock edge -> busy=0, done=0, dout=0 immediately; no done after release.
